// File: rtl/p2s_pkg.sv
// -----------------------------------------------------------------------------
// p2s_pkg
// Shared definitions for the parallel-to-serial converter.
//   - Frame-format mode encodings (2-bit, sampled per word on load).
//   - FSM state encoding.
//   - Small decode helpers that turn a mode into its frame properties.
// -----------------------------------------------------------------------------
package p2s_pkg;

    // Frame formats: bit 0 selects LSB-first, bit 1 appends a parity bit.
    localparam logic [1:0] MODE_MSB    = 2'b00;  // MSB first, WIDTH bits
    localparam logic [1:0] MODE_LSB    = 2'b01;  // LSB first, WIDTH bits
    localparam logic [1:0] MODE_MSB_EP = 2'b10;  // MSB first + even parity
    localparam logic [1:0] MODE_LSB_OP = 2'b11;  // LSB first + odd parity

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True when the frame carries a trailing parity bit.
    function automatic logic mode_has_parity(input logic [1:0] mode);
        return (mode == MODE_MSB_EP) || (mode == MODE_LSB_OP);
    endfunction

    // True when data bits leave LSB first.
    function automatic logic mode_lsb_first(input logic [1:0] mode);
        return (mode == MODE_LSB) || (mode == MODE_LSB_OP);
    endfunction

    // True when the parity bit is odd (~^data) rather than even (^data).
    function automatic logic mode_odd_parity(input logic [1:0] mode);
        return (mode == MODE_LSB_OP);
    endfunction

endpackage : p2s_pkg

// File: rtl/p2s_conver.sv
// -----------------------------------------------------------------------------
// p2s_conver
// Parallel-to-serial converter. A WIDTH-bit word is accepted through a
// valid/ready handshake and shifted out one bit per clock. The per-word mode
// selects bit order and an optional appended parity bit. A new word may be
// accepted during the last-bit cycle so frames can run back to back.
//
// Parameters
//   WIDTH        parallel word width (must be >= 2)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_in      parallel word, sampled only on acceptance
//   mode         frame format (see p2s_pkg), sampled only on acceptance
//   load_valid   data_in/mode are offered
//   load_ready   converter accepts a word this cycle (registers only)
//   ser_out      serial data bit (0 when ser_valid is 0)
//   ser_valid    ser_out carries a frame bit
//   frame_start  current bit is the first of its frame
//   frame_last   current bit is the last of its frame
// -----------------------------------------------------------------------------
module p2s_conver
    import p2s_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_PLAIN = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_PAR   = CNT_W'(WIDTH);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   last_q;    // L-1 for the frame in flight
    logic [WIDTH-1:0]   word_q;    // captured word
    logic               lsb_q;     // captured bit order
    logic               parity_q;  // parity of the captured word

    // Next-state values
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   last_n;
    logic [WIDTH-1:0]   word_n;
    logic               lsb_n;
    logic               parity_n;
    logic               bit_n;
    logic [CNT_W-1:0]   idx_n;

    logic               accept;

    // Ready only in IDLE or on the last bit of a frame; never looks at
    // load_valid, so there is no combinational path input -> load_ready.
    assign load_ready = (state == ST_IDLE) ||
                        ((state == ST_SHIFT) && (cnt == last_q));
    assign accept     = load_valid && load_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last_q;
        word_n   = word_q;
        lsb_n    = lsb_q;
        parity_n = parity_q;

        if (accept) begin
            // Capture word, format and parity together; later input changes
            // cannot affect this frame.
            state_n  = ST_SHIFT;
            cnt_n    = '0;
            word_n   = data_in;
            lsb_n    = mode_lsb_first(mode);
            last_n   = mode_has_parity(mode) ? LAST_PAR : LAST_PLAIN;
            parity_n = mode_odd_parity(mode) ? ~^data_in : ^data_in;
        end else if (state == ST_SHIFT) begin
            if (cnt == last_q) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n   = cnt + 1'b1;
            end
        end
    end

    // Bit presented for the next cycle. Outputs are computed from next-state
    // values so they can be registered yet still line up with cnt.
    always_comb begin
        idx_n = lsb_n ? cnt_n : (LAST_PLAIN - cnt_n);
        bit_n = 1'b0;
        if (cnt_n == LAST_PAR) begin
            bit_n = parity_n;
        end else if (idx_n < CNT_W'(WIDTH)) begin
            bit_n = word_n[idx_n];
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the captured word is reset along with control so ser_out can never
    // show X from an unloaded register after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_q      <= LAST_PLAIN;
            word_q      <= '0;
            lsb_q       <= 1'b0;
            parity_q    <= 1'b0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_q      <= last_n;
            word_q      <= word_n;
            lsb_q       <= lsb_n;
            parity_q    <= parity_n;
            ser_valid   <= (state_n == ST_SHIFT);
            ser_out     <= (state_n == ST_SHIFT) && bit_n;
            frame_start <= (state_n == ST_SHIFT) && (cnt_n == '0);
            frame_last  <= (state_n == ST_SHIFT) && (cnt_n == last_n);
        end
    end

endmodule : p2s_conver

// File: tb/tb_p2s_conver.sv
// -----------------------------------------------------------------------------
// tb_p2s_conver
// Scoreboard bench for p2s_conver (WIDTH=6). Stimulus pushes hand-computed
// frame bits into a queue; a negedge monitor pops and compares whenever
// ser_valid is high and checks idle outputs otherwise.
// -----------------------------------------------------------------------------
module tb_p2s_conver;
    import p2s_pkg::*;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       mode;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;

    p2s_conver #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .mode        (mode),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs only change at posedge, so negedge sampling is stable.
    always @(negedge clk) begin
        if (rst_n) begin
            check("load_ready", load_ready, !ser_valid || frame_last);
            if (ser_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ser_out",     ser_out,     e.b);
                    check("frame_start", frame_start, e.first);
                    check("frame_last",  frame_last,  e.last);
                end
            end else begin
                run_len = 0;
                check("idle_outputs", {ser_out, frame_start, frame_last}, 0);
            end
        end
    end

    // Offer one word; bits[len-1] is the first bit on the wire. Only the first
    // npush bits are expected (used when a reset cuts a frame short).
    task automatic send(input logic [5:0] d, input logic [1:0] m,
                        input logic [6:0] bits, input int len,
                        input int npush, input bit hold);
        int waited = 0;
        @(negedge clk);
        data_in    = d;
        mode       = m;
        load_valid = 1'b1;
        while (!load_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                check("ready_timeout", 0, 1);
                load_valid = 1'b0;
                return;
            end
        end
        for (int i = 0; i < npush; i++) begin
            exp_t e;
            e.b     = bits[len-1-i];
            e.first = (i == 0);
            e.last  = (i == len - 1);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            load_valid = 1'b0;
            data_in    = 6'($urandom);
            mode       = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!ser_valid && q.size() == 0) break;
            n++;
            if (n > 60) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        data_in    = '0;
        mode       = '0;
        load_valid = 1'b0;
        #3;
        check("reset_outputs", {ser_out, ser_valid, frame_start, frame_last}, 0);
        check("reset_ready", load_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single frames in each mode.
        send(6'b101100, MODE_MSB,    7'b0101100, 6, 6, 0); wait_idle();
        send(6'b101100, MODE_LSB,    7'b0001101, 6, 6, 0); wait_idle();
        send(6'b101100, MODE_MSB_EP, 7'b1011001, 7, 7, 0); wait_idle();
        send(6'b100001, MODE_LSB_OP, 7'b1000011, 7, 7, 0); wait_idle();
        send(6'b100011, MODE_LSB_OP, 7'b1100010, 7, 7, 0); wait_idle();

        // Back-to-back with load_valid held high across the first frame.
        max_run = 0;
        send(6'h2A, MODE_MSB, 7'b0101010, 6, 6, 1);
        send(6'h15, MODE_LSB, 7'b0101010, 6, 6, 0);
        wait_idle();
        check("b2b_run_length", max_run, 12);

        // Inputs churn mid-frame; a load_valid pulse while not ready is ignored.
        send(6'b110100, MODE_LSB_OP, 7'b0010110, 7, 7, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_in    = 6'($urandom);
            mode       = 2'($urandom);
            load_valid = (i == 2);
        end
        wait_idle();

        // Reset after the third bit of a mode 10 frame.
        send(6'b101100, MODE_MSB_EP, 7'b1011001, 7, 3, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {ser_out, ser_valid, frame_start, frame_last}, 0);
        check("midframe_reset_ready", load_ready, 1);
        check("midframe_reset_queue", q.size(), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(6'h3F, MODE_MSB_EP, 7'b1111110, 7, 7, 0);
        wait_idle();

        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_p2s_conver
